// File: rtl/univ_shiftreg.sv
// univ_shiftreg: universal shift register of DEPTH stages, WIDTH bits each.
// Operations: hold, shift right, shift left, parallel load, with a saturating
// count of shifts since the last clear (fill) and a full flag.
// Optional feature: define UNIV_SHIFTREG_ROTATE_EN to add the `rot` input,
// which turns both shift directions into rotations that leave fill untouched.
// All outputs are taken straight from registers or a decode of them.
module univ_shiftreg #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       clear,
    input  logic [1:0]                 mode,
    input  logic [WIDTH-1:0]           sin_r,
    input  logic [WIDTH-1:0]           sin_l,
    input  logic [WIDTH*DEPTH-1:0]     pin,
`ifdef UNIV_SHIFTREG_ROTATE_EN
    input  logic                       rot,
`endif
    output logic [WIDTH*DEPTH-1:0]     pout,
    output logic [WIDTH-1:0]           sout_r,
    output logic [WIDTH-1:0]           sout_l,
    output logic [$clog2(DEPTH+1)-1:0] fill,
    output logic                       full
);

    localparam int                FILL_W   = $clog2(DEPTH + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    // Packed so that stage i sits at bits [WIDTH*(i+1)-1 : WIDTH*i],
    // which is exactly the pin/pout mapping.
    logic [DEPTH-1:0][WIDTH-1:0] stage_q;
    logic [DEPTH-1:0][WIDTH-1:0] stage_d;
    logic [FILL_W-1:0]           fill_q;
    logic [FILL_W-1:0]           fill_d;
    logic                        rot_en;

    // Saturating increment: fill stops at DEPTH and never wraps.
    function automatic logic [FILL_W-1:0] fill_sat_inc(input logic [FILL_W-1:0] v);
        if (v >= FILL_MAX) begin
            return FILL_MAX;
        end
        return v + FILL_W'(1);
    endfunction

`ifdef UNIV_SHIFTREG_ROTATE_EN
    assign rot_en = rot;
`else
    assign rot_en = 1'b0;
`endif

    // Next-state selection for the stages and the shift counter.
    always_comb begin
        stage_d = stage_q;
        fill_d  = fill_q;
        case (mode)
            MODE_HOLD: begin
                stage_d = stage_q;
            end
            MODE_RIGHT: begin
                // Stage 0 is fed from sin_r, or from the last stage when rotating.
                stage_d = {stage_q[DEPTH-2:0], (rot_en ? stage_q[DEPTH-1] : sin_r)};
                if (!rot_en) begin
                    fill_d = fill_sat_inc(fill_q);
                end
            end
            MODE_LEFT: begin
                // Last stage is fed from sin_l, or from stage 0 when rotating.
                stage_d = {(rot_en ? stage_q[0] : sin_l), stage_q[DEPTH-1:1]};
                if (!rot_en) begin
                    fill_d = fill_sat_inc(fill_q);
                end
            end
            MODE_LOAD: begin
                stage_d = pin;
                fill_d  = FILL_MAX;
            end
            default: begin
                stage_d = stage_q;
            end
        endcase
    end

    // State register; clear (active-low, synchronous) overrides any operation.
    always_ff @(posedge clk) begin
        if (!clear) begin
            stage_q <= '0;
            fill_q  <= '0;
        end else begin
            stage_q <= stage_d;
            fill_q  <= fill_d;
        end
    end

    assign pout   = stage_q;
    assign sout_r = stage_q[DEPTH-1];
    assign sout_l = stage_q[0];
    assign fill   = fill_q;
    assign full   = (fill_q == FILL_MAX);

endmodule

// File: tb/tb_univ_shiftreg.sv
// Self-checking bench for univ_shiftreg (WIDTH=1, DEPTH=4): directed steps
// from the requirement examples followed by random operations, all compared
// against a queue-based reference model.
module tb_univ_shiftreg;

    localparam int W  = 1;
    localparam int D  = 4;
    localparam int FW = $clog2(D + 1);

    logic           clk = 1'b0;
    logic           clear;
    logic [1:0]     mode;
    logic [W-1:0]   sin_r;
    logic [W-1:0]   sin_l;
    logic [W*D-1:0] pin;
`ifdef UNIV_SHIFTREG_ROTATE_EN
    logic           rot;
`endif
    logic [W*D-1:0] pout;
    logic [W-1:0]   sout_r;
    logic [W-1:0]   sout_l;
    logic [FW-1:0]  fill;
    logic           full;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: queue element i is stage i; mfill counts shifts.
    logic [W-1:0] m[$];
    int           mfill;

    always #5 clk = ~clk;

    univ_shiftreg #(.WIDTH(W), .DEPTH(D)) dut (
        .clk   (clk),
        .clear (clear),
        .mode  (mode),
        .sin_r (sin_r),
        .sin_l (sin_l),
        .pin   (pin),
`ifdef UNIV_SHIFTREG_ROTATE_EN
        .rot   (rot),
`endif
        .pout  (pout),
        .sout_r(sout_r),
        .sout_l(sout_l),
        .fill  (fill),
        .full  (full)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W*D-1:0] model_pout();
        logic [W*D-1:0] r;
        r = '0;
        for (int i = 0; i < D; i++) r[i*W +: W] = m[i];
        return r;
    endfunction

    task automatic model_apply(input logic c, input logic [1:0] md, input logic [W-1:0] sr,
                               input logic [W-1:0] sl, input logic [W*D-1:0] p, input logic rt);
        logic [W-1:0] t;
        if (!c) begin
            for (int i = 0; i < D; i++) m[i] = '0;
            mfill = 0;
        end else if (md == 2'b01) begin
            t = rt ? m[D-1] : sr;
            m.push_front(t);
            void'(m.pop_back());
            if (!rt) mfill = (mfill + 1 > D) ? D : mfill + 1;
        end else if (md == 2'b10) begin
            t = rt ? m[0] : sl;
            m.push_back(t);
            void'(m.pop_front());
            if (!rt) mfill = (mfill + 1 > D) ? D : mfill + 1;
        end else if (md == 2'b11) begin
            for (int i = 0; i < D; i++) m[i] = p[i*W +: W];
            mfill = D;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pout"},   32'(pout),   32'(model_pout()));
        chk({tag, ".sout_r"}, 32'(sout_r), 32'(m[D-1]));
        chk({tag, ".sout_l"}, 32'(sout_l), 32'(m[0]));
        chk({tag, ".fill"},   32'(fill),   32'(mfill));
        chk({tag, ".full"},   32'(full),   32'(mfill == D));
    endtask

    // One clock: drive inputs, take the edge, advance the model, compare.
    task automatic step(input string tag, input logic c, input logic [1:0] md,
                        input logic [W-1:0] sr, input logic [W-1:0] sl,
                        input logic [W*D-1:0] p, input logic rt);
        clear = c;
        mode  = md;
        sin_r = sr;
        sin_l = sl;
        pin   = p;
`ifdef UNIV_SHIFTREG_ROTATE_EN
        rot   = rt;
`endif
        @(posedge clk);
        model_apply(c, md, sr, sl, p, rt);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [3:0]     sin_seq;
        int             fill_seq[6];
        logic [W*D-1:0] held;
        logic           c;
        logic [1:0]     md;

        for (int i = 0; i < D; i++) m.push_back('0);
        mfill    = 0;
        sin_seq  = 4'b1101;   // applied LSB first: 1,0,1,1
        fill_seq = '{1, 2, 3, 4, 4, 4};

        // Clear wins over parallel load of all ones.
        step("clr_load", 1'b0, 2'b11, 1'b0, 1'b0, 4'b1111, 1'b0);
        chk("clr.pout", 32'(pout), 32'h0);
        chk("clr.fill", 32'(fill), 32'h0);
        chk("clr.full", 32'(full), 32'h0);

        // Four right shifts of 1,0,1,1.
        for (int i = 0; i < 4; i++)
            step("shr_seq", 1'b1, 2'b01, W'(sin_seq[i]), 1'b0, '0, 1'b0);
        chk("shr4.pout",   32'(pout),   32'hB);
        chk("shr4.sout_r", 32'(sout_r), 32'h1);
        chk("shr4.fill",   32'(fill),   32'h4);
        chk("shr4.full",   32'(full),   32'h1);

        // Load 1001 then one left shift with sin_l=0.
        step("load", 1'b1, 2'b11, 1'b0, 1'b0, 4'b1001, 1'b0);
        step("shl1", 1'b1, 2'b10, 1'b1, 1'b0, 4'b1111, 1'b0);
        chk("shl1.pout", 32'(pout), 32'h4);
        chk("shl1.fill", 32'(fill), 32'h4);

        // Fill saturation over six right shifts, then three holds.
        step("clr2", 1'b0, 2'b01, 1'b1, 1'b1, '0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step("sat", 1'b1, 2'b01, W'($urandom), W'($urandom), W*D'($urandom), 1'b0);
            chk("sat.fill", 32'(fill), 32'(fill_seq[i]));
        end
        held = model_pout();
        for (int i = 0; i < 3; i++) begin
            step("hold", 1'b1, 2'b00, W'($urandom), W'($urandom), W*D'($urandom), 1'b0);
            chk("hold.pout", 32'(pout), 32'(held));
            chk("hold.fill", 32'(fill), 32'h4);
        end

        // Clear in the middle of a right-shift sequence.
        step("mid1", 1'b1, 2'b01, 1'b1, 1'b0, '0, 1'b0);
        step("mid2", 1'b0, 2'b01, 1'b1, 1'b0, '0, 1'b0);
        chk("midclr.pout", 32'(pout), 32'h0);
        chk("midclr.fill", 32'(fill), 32'h0);
        step("mid3", 1'b1, 2'b01, 1'b1, 1'b0, '0, 1'b0);
        chk("after.pout", 32'(pout), 32'h1);
        chk("after.fill", 32'(fill), 32'h1);

`ifdef UNIV_SHIFTREG_ROTATE_EN
        // Rotation: 0001 -> 0010 after one edge, back to 0001 after four.
        step("rload", 1'b1, 2'b11, 1'b0, 1'b0, 4'b0001, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step("rot", 1'b1, 2'b01, 1'b1, 1'b1, '0, 1'b1);
            if (i == 0) chk("rot1.pout", 32'(pout), 32'h2);
            chk("rot.fill", 32'(fill), 32'h4);
        end
        chk("rot4.pout", 32'(pout), 32'h1);
        for (int i = 0; i < 20; i++)
            step("rotrand", 1'b1, 2'($urandom_range(0, 3)), W'($urandom), W'($urandom),
                 W*D'($urandom), 1'($urandom));
`endif

        // Random operations, occasional clears.
        for (int i = 0; i < 300; i++) begin
            c  = ($urandom_range(0, 15) != 0);
            md = 2'($urandom_range(0, 3));
            step("rand", c, md, W'($urandom), W'($urandom), W*D'($urandom), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/univ_shiftreg.md
UNIV_SHIFTREG -- requirements
Module: univ_shiftreg

Interface
REQ-001 The module SHALL have parameter WIDTH, default 1, giving the bit width of each stage; legal values are 1 or more.
REQ-002 The module SHALL have parameter DEPTH, default 4, giving the number of stages; legal values are 2 or more.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on the rising edge only.
REQ-004 Port clear, input, 1 bit: reset; it SHALL be synchronous and active-low.
REQ-005 Port mode, input, 2 bits: operation select; 00 = hold, 01 = shift right, 10 = shift left, 11 = parallel load.
REQ-006 Port sin_r, input, WIDTH bits: serial input into stage 0 during a right shift.
REQ-007 Port sin_l, input, WIDTH bits: serial input into stage DEPTH-1 during a left shift.
REQ-008 Port pin, input, WIDTH*DEPTH bits: parallel load data; bits [WIDTH*(i+1)-1 : WIDTH*i] map to stage i.
REQ-009 Port pout, output, WIDTH*DEPTH bits: all stages, using the same mapping as pin.
REQ-010 Port sout_r, output, WIDTH bits: the content of stage DEPTH-1.
REQ-011 Port sout_l, output, WIDTH bits: the content of stage 0.
REQ-012 Port fill, output, clog2(DEPTH+1) bits: number of shift operations since the last clear, saturating at DEPTH.
REQ-013 Port full, output, 1 bit: high when fill equals DEPTH.

Function
REQ-014 All outputs SHALL come directly from registers or from a decode of register state only, with no combinational path from any input.
REQ-015 In hold mode (00), all stages and fill SHALL keep their values.
REQ-016 In shift-right mode (01), stage i SHALL take stage i-1 for i from 1 to DEPTH-1, and stage 0 SHALL take sin_r.
REQ-017 In shift-left mode (10), stage i SHALL take stage i+1 for i from 0 to DEPTH-2, and stage DEPTH-1 SHALL take sin_l.
REQ-018 In parallel-load mode (11), all stages SHALL take pin in one cycle, and fill SHALL be set to DEPTH.
REQ-019 Each non-rotating shift in either direction SHALL increment fill by 1; fill SHALL saturate at DEPTH and never wrap.
REQ-020 Latency: a value applied on sin_r SHALL appear on sout_r after exactly DEPTH consecutive right-shift edges; sin_l reaches sout_l under the same rule for left shifts.
REQ-021 A hold cycle placed between shifts SHALL stall data movement without losing or duplicating any stage.

Reset
REQ-022 When clear=0 at a rising edge, every stage SHALL become 0, fill SHALL become 0 and full SHALL become 0, whatever the value of mode.
REQ-023 clear SHALL take priority over any operation in the same cycle, including clear asserted in the middle of a shift sequence.
REQ-024 After clear returns to 1, the first edge SHALL perform the operation selected by mode.

Configuration
REQ-025 With macro UNIV_SHIFTREG_ROTATE_EN defined, the module SHALL add an input port rot, 1 bit.
REQ-026 With the macro defined and rot=1, a right shift SHALL load stage 0 from stage DEPTH-1, and a left shift SHALL load stage DEPTH-1 from stage 0; sin_r and sin_l SHALL be ignored and fill SHALL be unchanged.
REQ-027 Without UNIV_SHIFTREG_ROTATE_EN, the rot port SHALL be absent, and shifts SHALL always use sin_r and sin_l.

Verification (WIDTH=1, DEPTH=4)
REQ-028 Hold clear=0 for 1 edge with mode=11 and pin=4'b1111 -> pout=0, fill=0, full=0.
REQ-029 After clear, apply mode=01 with sin_r=1,0,1,1 over 4 edges -> pout=4'b1011, sout_r=1 after the 4th edge, fill=4, full=1.
REQ-030 Apply mode=11 with pin=4'b1001, then mode=10 with sin_l=0 for 1 edge -> pout=4'b0100, fill=4.
REQ-031 Apply 6 right shifts after clear -> fill=1,2,3,4,4,4; then mode=00 for 3 edges -> pout and fill unchanged.
REQ-032 Apply clear=0 during the 2nd edge of a right-shift sequence -> pout=0, fill=0; the next edge with clear=1 and sin_r=1 -> pout=4'b0001, fill=1.
REQ-033 With UNIV_SHIFTREG_ROTATE_EN: load 4'b0001, then rot=1 with mode=01 -> 4'b0010 after 1 edge and 4'b0001 after 4 edges, with fill=4 throughout.
